// File: rtl/dma_bus_write_ctrl_if.sv
// Bus bundle for the DMA write/control block: instruction strobe, write data,
// transfer step, and the register views plus read-mux steering it drives back.
interface dma_bus_write_ctrl_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned WW = 4
);
    logic [2:0]    instr;
    logic          instr_valid;
    logic [3:0]    data_in;
    logic          cnt_step;
    logic [2:0]    ctrl_reg_out;
    logic [AW-1:0] add_cnt_out;
    logic [WW-1:0] word_cnt_out;
    logic [1:0]    seld;
    logic          data_oe;
    logic          armed;
    logic          done;

    // Driver side (sequencer / testbench)
    modport master (
        output instr, instr_valid, data_in, cnt_step,
        input  ctrl_reg_out, add_cnt_out, word_cnt_out, seld, data_oe, armed, done
    );

    // Controller side
    modport slave (
        input  instr, instr_valid, data_in, cnt_step,
        output ctrl_reg_out, add_cnt_out, word_cnt_out, seld, data_oe, armed, done
    );
endinterface

// File: rtl/dma_bus_write_ctrl.sv
// Write-side/control end of the 4-bit DMA bus. Decodes Am2940-style instructions,
// loads control/address/word registers, steps the counters on transfer strobes
// and raises a sticky terminal-count flag.
module dma_bus_write_ctrl #(
    parameter int unsigned AW = 4,
    parameter int unsigned WW = 4
) (
    input logic                 clk,
    input logic                 rst,
    dma_bus_write_ctrl_if.slave bus
);
    localparam logic [2:0] OpWrcr   = 3'b000;
    localparam logic [2:0] OpRdcr   = 3'b001;
    localparam logic [2:0] OpRdwc   = 3'b010;
    localparam logic [2:0] OpRdac   = 3'b011;
    localparam logic [2:0] OpReinit = 3'b100;
    localparam logic [2:0] OpLdadr  = 3'b101;
    localparam logic [2:0] OpLdwc   = 3'b110;
    localparam logic [2:0] OpEncnt  = 3'b111;

    localparam logic [AW-1:0] AddrOne = AW'(1);
    localparam logic [WW-1:0] WordOne = WW'(1);

    logic [2:0]    ctrl_q, ctrl_d;
    logic [AW-1:0] add_reg_q, add_reg_d;
    logic [AW-1:0] add_cnt_q, add_cnt_d;
    logic [WW-1:0] word_reg_q, word_reg_d;
    logic [WW-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]    seld_q, seld_d;
    logic          data_oe_q, data_oe_d;
    logic          armed_q, armed_d;
    logic          done_q, done_d;

    logic [1:0]    mode;
    logic          step_en;
    logic          terminal;

    assign mode = ctrl_q[1:0];

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            add_reg_q  <= '0;
            add_cnt_q  <= '0;
            word_reg_q <= '0;
            word_cnt_q <= '0;
            seld_q     <= '0;
            data_oe_q  <= 1'b0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            add_reg_q  <= add_reg_d;
            add_cnt_q  <= add_cnt_d;
            word_reg_q <= word_reg_d;
            word_cnt_q <= word_cnt_d;
            seld_q     <= seld_d;
            data_oe_q  <= data_oe_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
        end
    end

    // Next state: instructions take priority, a step in the same cycle is dropped
    always_comb begin
        ctrl_d     = ctrl_q;
        add_reg_d  = add_reg_q;
        add_cnt_d  = add_cnt_q;
        word_reg_d = word_reg_q;
        word_cnt_d = word_cnt_q;
        seld_d     = seld_q;
        data_oe_d  = 1'b0;
        armed_d    = armed_q;
        done_d     = done_q;
        terminal   = 1'b0;
        step_en    = bus.cnt_step && armed_q && !done_q && !bus.instr_valid;

        if (bus.instr_valid) begin
            unique case (bus.instr)
                OpWrcr: begin
                    ctrl_d  = bus.data_in[2:0];
                    done_d  = 1'b0;
                    armed_d = 1'b0;
                end
                OpRdcr: begin
                    seld_d    = 2'b10;
                    data_oe_d = 1'b1;
                end
                OpRdwc: begin
                    seld_d    = 2'b01;
                    data_oe_d = 1'b1;
                end
                OpRdac: begin
                    seld_d    = 2'b00;
                    data_oe_d = 1'b1;
                end
                OpReinit: begin
                    add_cnt_d  = add_reg_q;
                    word_cnt_d = (mode == 2'b01) ? '0 : word_reg_q;
                    done_d     = 1'b0;
                end
                OpLdadr: begin
                    add_reg_d = AW'(bus.data_in);
                    add_cnt_d = AW'(bus.data_in);
                end
                OpLdwc: begin
                    word_reg_d = WW'(bus.data_in);
                    word_cnt_d = (mode == 2'b01) ? '0 : WW'(bus.data_in);
                    done_d     = 1'b0;
                end
                OpEncnt: begin
                    if (!done_q) armed_d = 1'b1;
                end
                default: ;
            endcase
        end else if (step_en) begin
            add_cnt_d = ctrl_q[2] ? add_cnt_q - AddrOne : add_cnt_q + AddrOne;
            unique case (mode)
                2'b00: begin
                    word_cnt_d = word_cnt_q - WordOne;
                    terminal   = (word_cnt_d == '0);
                end
                2'b01: begin
                    word_cnt_d = word_cnt_q + WordOne;
                    terminal   = (word_cnt_d == word_reg_q);
                end
                // Address-only modes: word counter frozen, never terminal
                default: ;
            endcase
            if (terminal) begin
                done_d  = 1'b1;
                armed_d = 1'b0;
            end
        end
    end

    // Outputs come straight from registers
    always_comb begin
        bus.ctrl_reg_out = ctrl_q;
        bus.add_cnt_out  = add_cnt_q;
        bus.word_cnt_out = word_cnt_q;
        bus.seld         = seld_q;
        bus.data_oe      = data_oe_q;
        bus.armed        = armed_q;
        bus.done         = done_q;
    end
endmodule

// File: tb/tb_dma_bus_write_ctrl.sv
// Self-checking bench for dma_bus_write_ctrl: behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_dma_bus_write_ctrl;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dma_bus_write_ctrl_if #(.AW(4), .WW(4)) bus ();

    dma_bus_write_ctrl #(.AW(4), .WW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers, modulo-16 arithmetic
    int m_ctrl, m_areg, m_acnt, m_wreg, m_wcnt, m_seld, m_oe, m_armed, m_done;
    int m_mode, m_data;
    bit live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ctrl = 0; m_areg = 0; m_acnt = 0; m_wreg = 0; m_wcnt = 0;
            m_seld = 0; m_oe = 0; m_armed = 0; m_done = 0;
            live = 1'b1;
        end else begin
            m_mode = m_ctrl % 4;
            m_data = int'(bus.data_in);
            m_oe = 0;
            if (bus.instr_valid) begin
                case (bus.instr)
                    3'd0: begin m_ctrl = m_data % 8; m_done = 0; m_armed = 0; end
                    3'd1: begin m_seld = 2; m_oe = 1; end
                    3'd2: begin m_seld = 1; m_oe = 1; end
                    3'd3: begin m_seld = 0; m_oe = 1; end
                    3'd4: begin
                        m_acnt = m_areg;
                        m_wcnt = (m_mode == 1) ? 0 : m_wreg;
                        m_done = 0;
                    end
                    3'd5: begin m_areg = m_data; m_acnt = m_data; end
                    3'd6: begin
                        m_wreg = m_data;
                        m_wcnt = (m_mode == 1) ? 0 : m_data;
                        m_done = 0;
                    end
                    default: if (m_done == 0) m_armed = 1;
                endcase
            end else if (bus.cnt_step && m_armed == 1 && m_done == 0) begin
                m_acnt = (m_ctrl >= 4) ? (m_acnt + 15) % 16 : (m_acnt + 1) % 16;
                if (m_mode == 0) begin
                    m_wcnt = (m_wcnt + 15) % 16;
                    if (m_wcnt == 0) begin m_done = 1; m_armed = 0; end
                end else if (m_mode == 1) begin
                    m_wcnt = (m_wcnt + 1) % 16;
                    if (m_wcnt == m_wreg) begin m_done = 1; m_armed = 0; end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (live) begin
            chk("m_ctrl",  32'(bus.ctrl_reg_out), 32'(m_ctrl));
            chk("m_acnt",  32'(bus.add_cnt_out),  32'(m_acnt));
            chk("m_wcnt",  32'(bus.word_cnt_out), 32'(m_wcnt));
            chk("m_seld",  32'(bus.seld),         32'(m_seld));
            chk("m_oe",    32'(bus.data_oe),      32'(m_oe));
            chk("m_armed", 32'(bus.armed),        32'(m_armed));
            chk("m_done",  32'(bus.done),         32'(m_done));
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the edge that consumed them
    task automatic tick(input logic r, input logic v, input logic [2:0] op,
                        input logic [3:0] d, input logic s);
        rst             = r;
        bus.instr_valid = v;
        bus.instr       = op;
        bus.data_in     = d;
        bus.cnt_step    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic random_burst(input int n);
        for (int i = 0; i < n; i++) begin
            tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 3'($urandom), 4'($urandom), 1'($urandom));
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] a, input logic [3:0] w,
                             input logic dn, input logic ar);
        chk({tag, " add_cnt"},  32'(bus.add_cnt_out),  32'(a));
        chk({tag, " word_cnt"}, 32'(bus.word_cnt_out), 32'(w));
        chk({tag, " done"},     32'(bus.done),         32'(dn));
        chk({tag, " armed"},    32'(bus.armed),        32'(ar));
    endtask

    initial begin
        tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        random_burst(300);

        // Reset after activity, with a step and instruction presented during reset
        tick(1'b1, 1'b1, 3'd7, 4'hF, 1'b1);
        tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
        chk_state("t1", 4'h0, 4'h0, 1'b0, 1'b0);
        chk("t1 ctrl",    32'(bus.ctrl_reg_out), 32'd0);
        chk("t1 seld",    32'(bus.seld),         32'd0);
        chk("t1 data_oe", 32'(bus.data_oe),      32'd0);

        // Increment address with wrap, mode 00 word down-count
        tick(1'b0, 1'b1, 3'd0, 4'h0, 1'b0);
        tick(1'b0, 1'b1, 3'd5, 4'hE, 1'b0);
        chk("t2 ldadr", 32'(bus.add_cnt_out), 32'hE);
        tick(1'b0, 1'b1, 3'd6, 4'h3, 1'b0);
        chk("t2 ldwc", 32'(bus.word_cnt_out), 32'h3);
        tick(1'b0, 1'b1, 3'd7, 4'h0, 1'b0);
        chk("t2 encnt", 32'(bus.armed), 32'd1);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        chk_state("t2 s1", 4'hF, 4'h2, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        chk_state("t2 s2", 4'h0, 4'h1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        chk_state("t2 s3", 4'h1, 4'h0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        chk_state("t2 s4", 4'h1, 4'h0, 1'b1, 1'b0);

        // Decrement address, mode 01 word up-count to word_reg
        tick(1'b0, 1'b1, 3'd0, 4'h5, 1'b0);
        chk("t3 ctrl", 32'(bus.ctrl_reg_out), 32'h5);
        tick(1'b0, 1'b1, 3'd5, 4'h2, 1'b0);
        tick(1'b0, 1'b1, 3'd6, 4'h2, 1'b0);
        chk("t3 ldwc", 32'(bus.word_cnt_out), 32'h0);
        tick(1'b0, 1'b1, 3'd7, 4'h0, 1'b0);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        chk_state("t3 s1", 4'h1, 4'h1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        chk_state("t3 s2", 4'h0, 4'h2, 1'b1, 1'b0);

        // Back-to-back reads
        tick(1'b0, 1'b1, 3'd2, 4'h0, 1'b0);
        chk("t4 seld rdwc", 32'(bus.seld), 32'd1);
        chk("t4 oe rdwc",   32'(bus.data_oe), 32'd1);
        tick(1'b0, 1'b1, 3'd3, 4'h0, 1'b0);
        chk("t4 seld rdac", 32'(bus.seld), 32'd0);
        chk("t4 oe rdac",   32'(bus.data_oe), 32'd1);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b0);
        chk("t4 seld hold", 32'(bus.seld), 32'd0);
        chk("t4 oe low",    32'(bus.data_oe), 32'd0);

        // Step blocked by a simultaneous instruction
        tick(1'b0, 1'b1, 3'd4, 4'h0, 1'b0);
        tick(1'b0, 1'b1, 3'd7, 4'h0, 1'b0);
        tick(1'b0, 1'b1, 3'd5, 4'h7, 1'b1);
        chk_state("t5", 4'h7, 4'h0, 1'b0, 1'b1);

        // REINIT after terminal count, then re-arm and resume counting
        tick(1'b0, 1'b1, 3'd0, 4'h0, 1'b0);
        tick(1'b0, 1'b1, 3'd5, 4'h5, 1'b0);
        tick(1'b0, 1'b1, 3'd6, 4'h2, 1'b0);
        tick(1'b0, 1'b1, 3'd7, 4'h0, 1'b0);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        chk_state("t6 done", 4'h7, 4'h0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 3'd7, 4'h0, 1'b0);
        chk("t6 encnt while done", 32'(bus.armed), 32'd0);
        tick(1'b0, 1'b1, 3'd4, 4'h0, 1'b0);
        chk_state("t6 reinit", 4'h5, 4'h2, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 3'd7, 4'h0, 1'b0);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        chk_state("t6 resume", 4'h6, 4'h1, 1'b0, 1'b1);

        random_burst(2000);
        tick(1'b0, 1'b0, 3'd0, 4'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
